demux_ctrl: RTL and testbench
=============================

DEMUX_CTRL -- requirements
Module: demux_ctrl

Interface
REQ-001 Parameter: DATA_BITS, 4, width of data word routed to the demux.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_L  input  1  asynchronous active-low reset.
REQ-005 valid_in  input  1  upstream word valid.
REQ-006 data_in  input  DATA_BITS  upstream word.
REQ-007 dest_in  input  2  destination channel 0..3 for data_in.
REQ-008 ready_out  output  1  block can accept a word this cycle.
REQ-009 pausa  input  4  per-channel backpressure; bit i high = channel i cannot take a word.
REQ-010 enb_dmux  output  1  demux enable, one-cycle pulse per routed word.
REQ-011 selector_dmux  output  2  demux select.
REQ-012 data_dmux  output  DATA_BITS  word presented to demux input.
REQ-013 idle_out  output  1  high when holding register empty and no pulse in flight.
REQ-014 cnt_sel  input  2  selects channel counter shown on cnt_out.
REQ-015 cnt_out  output  8  selected channel word count.

Function
REQ-016 The block SHALL hold one word in a holding register H (data, dest, full flag).
REQ-017 Accept = valid_in && ready_out; on accept, H SHALL load data_in/dest_in at the edge.
REQ-018 Issue = H.full && !pausa[H.dest], evaluated combinationally from current-cycle pausa.
REQ-019 ready_out SHALL equal !H.full || issue (same-cycle issue and accept allowed, 1 word/cycle throughput).
REQ-020 On issue edge: enb_dmux<=1, selector_dmux<=H.dest, data_dmux<=H.data; H.full cleared unless accept same edge.
REQ-021 Latency: word accepted at edge k, unpaused, SHALL appear with enb_dmux=1 in the cycle after edge k+1.
REQ-022 Without issue, enb_dmux<=0; selector_dmux and data_dmux SHALL hold last values.
REQ-023 FSM states: IDLE (H empty), LOAD (H full, dest unpaused), STALL (H full, dest paused).
REQ-024 Transitions: IDLE->LOAD/STALL on accept per pausa[dest_in] next cycle; LOAD->IDLE on issue without accept; LOAD->LOAD on issue+accept; STALL->LOAD when pausa[H.dest] drops.
REQ-025 pausa bits for channels other than H.dest SHALL NOT affect issue.
REQ-026 While valid_in low and H empty, no issue SHALL occur; data_in/dest_in ignored when not accepted.
REQ-027 idle_out SHALL be !H.full && !enb_dmux.

Reset
REQ-028 On reset_L low: H.full=0, state=IDLE, enb_dmux=0, selector_dmux=0, data_dmux=0, counters=0, asynchronously.
REQ-029 Reset mid-operation SHALL discard held word; no enb_dmux pulse for it after release.
REQ-030 ready_out SHALL be 1 in first cycle after reset release.

Configuration
REQ-031 Macro DEMUX_CTRL_CNT_EN defined: four 8-bit per-channel counters increment on each issue to that channel, wrap 255->0; cnt_out = counter[cnt_sel] combinationally.
REQ-032 Macro undefined: no counters synthesised; cnt_out tied 0; ports unchanged.

Verification
REQ-033 Reset, pausa=0, send 0xA dest 2 -> enb_dmux pulse 1 cycle, selector_dmux=2, data_dmux=0xA, 2 edges after accept.
REQ-034 Back-to-back words 1,2,3,4 to dest 0,1,2,3, pausa=0 -> ready_out stays 1, four consecutive enb_dmux pulses in order.
REQ-035 pausa=4'b0010, send 0x5 dest 1 -> STALL, ready_out=0, no pulse; drop pausa[1] -> pulse selector=1 data=0x5 next cycle.
REQ-036 pausa=4'b0010, H holds dest 3 word -> issues despite pausa[1]; stalled dest-1 word unaffected by pausa[0].
REQ-037 Word in STALL, assert reset_L low -> enb_dmux=0, idle_out=1; after release and pausa=0, no spurious pulse.
REQ-038 DEMUX_CTRL_CNT_EN defined, 257 words to dest 0 -> cnt_sel=0 gives cnt_out=1; other channels 0; undefined -> cnt_out=0.

Source files
------------

// File: rtl/demux_ctrl_if.sv
// demux_ctrl_if: upstream handshake, per-channel backpressure, demux drive
// and counter readout for demux_ctrl. The master modport belongs to whoever
// drives the block (upstream + demux side). The slave modport is the block.
interface demux_ctrl_if #(
  parameter int DATA_BITS = 4
);
  // upstream word
  logic                 valid_in;
  logic [DATA_BITS-1:0] data_in;
  logic [1:0]           dest_in;
  logic                 ready_out;
  // demux side
  logic [3:0]           pausa;
  logic                 enb_dmux;
  logic [1:0]           selector_dmux;
  logic [DATA_BITS-1:0] data_dmux;
  // status / counters
  logic                 idle_out;
  logic [1:0]           cnt_sel;
  logic [7:0]           cnt_out;

  modport master (
    output valid_in, data_in, dest_in, pausa, cnt_sel,
    input  ready_out, enb_dmux, selector_dmux, data_dmux, idle_out, cnt_out
  );

  modport slave (
    input  valid_in, data_in, dest_in, pausa, cnt_sel,
    output ready_out, enb_dmux, selector_dmux, data_dmux, idle_out, cnt_out
  );
endinterface

// File: rtl/demux_ctrl.sv
// demux_ctrl: one-word holding register in front of a 4-way demux.
// A word is accepted into H and issued to the demux as a one-cycle enb_dmux
// pulse once its destination channel is not paused. An issue and an accept
// may share an edge, which gives one word per cycle when unpaused.
// Optional build macro DEMUX_CTRL_CNT_EN adds four 8-bit per-channel issue
// counters readable through cnt_sel/cnt_out. Without it, cnt_out reads 0.

`ifdef DEMUX_CTRL_CNT_EN
// Per-channel wrapping issue counter.
module demux_ctrl_cnt (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);
  logic [7:0] cnt_q;

  // count issues to this channel; 8-bit wrap is intended
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 8'd1;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module demux_ctrl #(
  parameter int DATA_BITS = 4
) (
  input  logic         clk,
  input  logic         reset_L,
  demux_ctrl_if.slave  bus
);
  localparam int NUM_CH = 4;

  // IDLE: H empty. LOAD: H full and its channel open, so it issues this
  // cycle. STALL: H full and its channel paused.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] h_data_q, h_data_d;
  logic [1:0]           h_dest_q, h_dest_d;

  logic                 enb_q;
  logic [1:0]           sel_q, sel_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;

  logic                 h_full;
  logic                 issue;
  logic                 ready;
  logic                 accept;

  // H occupancy lives in the state encoding: any non-IDLE state means full.
  // Issue looks at the live pausa bit of H's own channel only, so the
  // registered LOAD/STALL distinction never gates issue.
  always_comb begin
    h_full = (state_q != S_IDLE);
    issue  = h_full && !bus.pausa[h_dest_q];
    ready  = !h_full || issue;
    accept = bus.valid_in && ready;
  end

  // next-state for FSM, holding register and demux drive registers
  always_comb begin
    state_d  = state_q;
    h_data_d = h_data_q;
    h_dest_d = h_dest_q;
    sel_d    = sel_q;
    dout_d   = dout_q;

    if (issue) begin
      sel_d  = h_dest_q;
      dout_d = h_data_q;
    end

    if (accept) begin
      h_data_d = bus.data_in;
      h_dest_d = bus.dest_in;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = bus.pausa[bus.dest_in] ? S_STALL : S_LOAD;
      end
      S_LOAD, S_STALL: begin
        // a freshly accepted word replaces the issued one; otherwise either
        // H drains, or it waits on a paused channel
        if (accept)     state_d = bus.pausa[bus.dest_in] ? S_STALL : S_LOAD;
        else if (issue) state_d = S_IDLE;
        else            state_d = S_STALL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and holding register; reset discards any held word
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      h_data_q <= '0;
      h_dest_q <= '0;
    end else begin
      state_q  <= state_d;
      h_data_q <= h_data_d;
      h_dest_q <= h_dest_d;
    end
  end

  // demux drive: enb pulses for one cycle per issue; select/data hold
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      enb_q  <= 1'b0;
      sel_q  <= '0;
      dout_q <= '0;
    end else begin
      enb_q  <= issue;
      sel_q  <= sel_d;
      dout_q <= dout_d;
    end
  end

  assign bus.ready_out     = ready;
  assign bus.enb_dmux      = enb_q;
  assign bus.selector_dmux = sel_q;
  assign bus.data_dmux     = dout_q;
  assign bus.idle_out      = !h_full && !enb_q;

`ifdef DEMUX_CTRL_CNT_EN
  logic [NUM_CH-1:0]      cnt_inc;
  logic [NUM_CH-1:0][7:0] cnt_vec;

  // one counter per channel; increment on the issue edge to that channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    assign cnt_inc[c] = issue && (h_dest_q == c[1:0]);
    demux_ctrl_cnt u_cnt (
      .clk    (clk),
      .reset_L(reset_L),
      .inc_i  (cnt_inc[c]),
      .cnt_o  (cnt_vec[c])
    );
  end

  assign bus.cnt_out = cnt_vec[bus.cnt_sel];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^bus.cnt_sel;
  assign bus.cnt_out    = 8'd0;
`endif
endmodule

// File: tb/tb_demux_ctrl.sv
// tb_demux_ctrl: directed bench for demux_ctrl. A queue-based reference
// (one-deep buffer + issue log) is compared against the outputs on every
// cycle, and literal expectations pin the headline scenarios.
// Build with DEMUX_CTRL_CNT_EN to also exercise the counters.
module tb_demux_ctrl;
  logic clk = 1'b0;
  logic reset_L = 1'b0;

  demux_ctrl_if #(.DATA_BITS(4)) bus ();

  demux_ctrl #(.DATA_BITS(4)) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference: H is a queue of capacity one; issue log is last issued word
  typedef struct packed {
    logic [1:0] dest;
    logic [3:0] data;
  } word_t;

  word_t      mq[$];
  word_t      mw;
  logic       m_enb;
  logic [1:0] m_sel;
  logic [3:0] m_data;
  int         m_cnt[4];
  bit         m_go, m_take;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mq.delete();
      m_enb  = 1'b0;
      m_sel  = 2'd0;
      m_data = 4'd0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    end else begin
      m_go   = (mq.size() != 0) && !bus.pausa[mq[0].dest];
      m_take = bus.valid_in && ((mq.size() == 0) || m_go);
      m_enb  = m_go;
      if (m_go) begin
        mw     = mq.pop_front();
        m_sel  = mw.dest;
        m_data = mw.data;
        m_cnt[mw.dest] = (m_cnt[mw.dest] + 1) % 256;
      end
      if (m_take) begin
        mw.dest = bus.dest_in;
        mw.data = bus.data_in;
        mq.push_back(mw);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // full-output comparison against the reference
  task automatic compare();
    logic exp_ready;
    logic [7:0] exp_cnt;
    exp_ready = (mq.size() == 0) ? 1'b1 : !bus.pausa[mq[0].dest];
`ifdef DEMUX_CTRL_CNT_EN
    exp_cnt = 8'(m_cnt[bus.cnt_sel]);
`else
    exp_cnt = 8'd0;
`endif
    chk("m_ready", bus.ready_out, exp_ready);
    chk("m_enb", bus.enb_dmux, m_enb);
    chk("m_sel", bus.selector_dmux, m_sel);
    chk("m_data", bus.data_dmux, m_data);
    chk("m_idle", bus.idle_out, (mq.size() == 0) && !m_enb);
    chk("m_cnt", bus.cnt_out, exp_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic send(input logic [1:0] d, input logic [3:0] v);
    bus.valid_in = 1'b1;
    bus.dest_in  = d;
    bus.data_in  = v;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 4'd0;
    bus.dest_in  = 2'd0;
    bus.pausa    = 4'd0;
    bus.cnt_sel  = 2'd0;

    // reset state
    #1 compare();
    repeat (2) tick();
    reset_L = 1'b1;
    chk("rst_ready", bus.ready_out, 1);
    chk("rst_enb", bus.enb_dmux, 0);
    chk("rst_sel", bus.selector_dmux, 0);
    chk("rst_data", bus.data_dmux, 0);
    chk("rst_idle", bus.idle_out, 1);

    // single word 0xA to channel 2: pulse two edges after accept
    send(2'd2, 4'hA);
    tick();
    bus.valid_in = 1'b0;
    chk("a_enb_early", bus.enb_dmux, 0);
    chk("a_busy", bus.idle_out, 0);
    tick();
    chk("a_enb", bus.enb_dmux, 1);
    chk("a_sel", bus.selector_dmux, 2);
    chk("a_data", bus.data_dmux, 4'hA);
    tick();
    chk("a_enb_off", bus.enb_dmux, 0);
    chk("a_sel_hold", bus.selector_dmux, 2);
    chk("a_data_hold", bus.data_dmux, 4'hA);
    chk("a_idle", bus.idle_out, 1);

    // back-to-back words 1..4 to channels 0..3
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 4'(i + 1));
      #1 chk("b_ready", bus.ready_out, 1);
      tick();
      if (i > 0) begin
        chk("b_enb", bus.enb_dmux, 1);
        chk("b_sel", bus.selector_dmux, i - 1);
        chk("b_data", bus.data_dmux, i);
      end
    end
    bus.valid_in = 1'b0;
    tick();
    chk("b_enb_last", bus.enb_dmux, 1);
    chk("b_sel_last", bus.selector_dmux, 3);
    chk("b_data_last", bus.data_dmux, 4);
    tick();
    chk("b_enb_off", bus.enb_dmux, 0);

    // stall on channel 1, then release
    bus.pausa = 4'b0010;
    send(2'd1, 4'h5);
    tick();
    bus.valid_in = 1'b0;
    #1 chk("s_ready", bus.ready_out, 0);
    repeat (2) begin
      tick();
      chk("s_enb", bus.enb_dmux, 0);
    end
    bus.pausa = 4'b0000;
    #1 chk("s_ready_rel", bus.ready_out, 1);
    tick();
    chk("s_enb_rel", bus.enb_dmux, 1);
    chk("s_sel_rel", bus.selector_dmux, 1);
    chk("s_data_rel", bus.data_dmux, 5);

    // other channels' pause bits do not matter
    bus.pausa = 4'b0010;
    send(2'd3, 4'h7);
    tick();
    bus.valid_in = 1'b0;
    tick();
    chk("o_enb3", bus.enb_dmux, 1);
    chk("o_sel3", bus.selector_dmux, 3);
    chk("o_data3", bus.data_dmux, 7);
    send(2'd1, 4'h9);
    tick();
    bus.valid_in = 1'b0;
    bus.pausa = 4'b0011;
    tick();
    chk("o_enb_stall", bus.enb_dmux, 0);
    bus.pausa = 4'b0001;
    #1 chk("o_ready", bus.ready_out, 1);
    tick();
    chk("o_enb1", bus.enb_dmux, 1);
    chk("o_sel1", bus.selector_dmux, 1);
    chk("o_data1", bus.data_dmux, 9);
    tick();

    // reset while a word is stalled discards it
    bus.pausa = 4'b0010;
    send(2'd1, 4'hC);
    tick();
    bus.valid_in = 1'b0;
    tick();
    reset_L = 1'b0;
    #1;
    chk("r_enb", bus.enb_dmux, 0);
    chk("r_idle", bus.idle_out, 1);
    compare();
    tick();
    reset_L = 1'b1;
    bus.pausa = 4'b0000;
    #1 chk("r_ready", bus.ready_out, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_no_pulse", bus.enb_dmux, 0);
    end

    // 257 words to channel 0: counter wraps to 1
    reset_L = 1'b0;
    #1 compare();
    tick();
    reset_L = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send(2'd0, 4'(i));
      tick();
    end
    bus.valid_in = 1'b0;
    repeat (2) tick();
    for (int c = 0; c < 4; c++) begin
      bus.cnt_sel = 2'(c);
      #1;
`ifdef DEMUX_CTRL_CNT_EN
      chk("c_cnt", bus.cnt_out, (c == 0) ? 1 : 0);
`else
      chk("c_cnt", bus.cnt_out, 0);
`endif
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
